// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: request/redirect inputs from the hazard and branch
// logic, current PC from the PC register, and the next-PC / fetch qualifier
// outputs back to the IF stage. The sequencer uses the slave modport.
interface fetch_sequencer_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] currentPC;
  logic            imem_ready;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            jump;
  logic [PC_W-1:0] jump_target;
  logic            halt;
  logic            resume;
  logic [PC_W-1:0] nextPC;
  logic            fetch_valid;
  logic            if_flush;
  logic            halted;

  modport master (
    output currentPC, imem_ready, stall, branch_taken, branch_target,
           jump, jump_target, halt, resume,
    input  nextPC, fetch_valid, if_flush, halted
  );

  modport slave (
    input  currentPC, imem_ready, stall, branch_taken, branch_target,
           jump, jump_target, halt, resume,
    output nextPC, fetch_valid, if_flush, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// IF-stage program counter controller. Produces nextPC every cycle from the
// current PC and the redirect / halt / stall / memory-ready requests, plus a
// fetch-valid qualifier and an IF/ID flush pulse.
// Optional feature macro: PC_CTRL_PERF_EN adds saturating redirect_cnt and
// stall_cnt performance counters as extra output ports.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal fetch, PC increments when memory is ready
// WAIT_MEM | memory not ready, PC held until imem_ready
// BUBBLE   | post-redirect bubbles, counter down to 1 then back to RUN
// HALTED   | PC frozen until resume or redirect
module fetch_sequencer #(
  parameter int PC_W             = 8,
  parameter int REDIRECT_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.slave  bus
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [15:0]       redirect_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_BUBBLE   = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  localparam logic [1:0] BUB_INIT = 2'(REDIRECT_BUBBLES);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_bub_cnt;
  logic [1:0]      w_bub_cnt_nxt;
  logic            r_halted;
  logic            w_redirect;
  logic [PC_W-1:0] w_next_pc;
  logic            w_fetch_valid;
  logic            w_if_flush;

  assign w_redirect = bus.jump | bus.branch_taken;

  // State, bubble counter and registered halted flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_bub_cnt <= 2'd0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bub_cnt <= w_bub_cnt_nxt;
      r_halted  <= (w_state_nxt == S_HALTED);
    end
  end

  // Next-state and next-PC selection: redirect > halt > stall > mem wait > increment
  always_comb begin
    w_state_nxt   = r_state;
    w_bub_cnt_nxt = r_bub_cnt;
    w_next_pc     = bus.currentPC;
    w_fetch_valid = 1'b0;
    w_if_flush    = 1'b0;
    if (w_redirect) begin
      w_next_pc  = bus.jump ? bus.jump_target : bus.branch_target;
      w_if_flush = 1'b1;
      if (BUB_INIT == 2'd0) begin
        w_state_nxt   = S_RUN;
        w_bub_cnt_nxt = 2'd0;
      end else begin
        w_state_nxt   = S_BUBBLE;
        w_bub_cnt_nxt = BUB_INIT;
      end
    end else if (bus.halt) begin
      // halt together with resume keeps the controller halted
      w_state_nxt   = S_HALTED;
      w_bub_cnt_nxt = 2'd0;
    end else begin
      case (r_state)
        S_HALTED: begin
          if (bus.resume) w_state_nxt = S_RUN;
        end
        S_BUBBLE: begin
          // stall does not extend the bubble window
          if (r_bub_cnt <= 2'd1) begin
            w_state_nxt   = S_RUN;
            w_bub_cnt_nxt = 2'd0;
          end else begin
            w_bub_cnt_nxt = r_bub_cnt - 2'd1;
          end
        end
        default: begin
          if (bus.stall) begin
            w_state_nxt = r_state;
          end else if (!bus.imem_ready) begin
            w_state_nxt = S_WAIT_MEM;
          end else begin
            w_next_pc     = bus.currentPC + PC_W'(1);
            w_fetch_valid = 1'b1;
            w_state_nxt   = S_RUN;
          end
        end
      endcase
    end
  end

  assign bus.nextPC      = w_next_pc;
  assign bus.fetch_valid = w_fetch_valid;
  assign bus.if_flush    = w_if_flush;
  assign bus.halted      = r_halted;

`ifdef PC_CTRL_PERF_EN
  logic [15:0] r_redirect_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_stall_evt;

  assign w_stall_evt = !w_fetch_valid && (r_state != S_HALTED);

  // Saturating counters of accepted redirects and non-fetch cycles outside HALTED
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_cnt <= 16'd0;
      r_stall_cnt    <= 16'd0;
    end else begin
      if (w_redirect && (r_redirect_cnt != 16'hFFFF))
        r_redirect_cnt <= r_redirect_cnt + 16'd1;
      if (w_stall_evt && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign redirect_cnt = r_redirect_cnt;
  assign stall_cnt    = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the driver issues directed vectors and
// queues hand-computed expected outputs; a negedge monitor pops and compares.
// dut uses one redirect bubble, dut3 uses three.
module tb_fetch_sequencer;
  localparam int PC_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(PC_W)) bus ();
  fetch_sequencer_if #(.PC_W(PC_W)) bus3 ();

`ifdef PC_CTRL_PERF_EN
  logic [15:0] redirect_cnt, stall_cnt, redirect_cnt3, stall_cnt3;
  logic [15:0] sc_snap;
`endif

  fetch_sequencer #(.PC_W(PC_W), .REDIRECT_BUBBLES(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef PC_CTRL_PERF_EN
    , .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
`endif
  );

  fetch_sequencer #(.PC_W(PC_W), .REDIRECT_BUBBLES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
`ifdef PC_CTRL_PERF_EN
    , .redirect_cnt(redirect_cnt3), .stall_cnt(stall_cnt3)
`endif
  );

  // PC register models; dut's can be loaded directly to reach test addresses
  logic            force_en  = 1'b0;
  logic [PC_W-1:0] force_val = '0;
  always @(posedge clk or posedge rst) begin
    if (rst)           bus.currentPC <= '0;
    else if (force_en) bus.currentPC <= force_val;
    else               bus.currentPC <= bus.nextPC;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) bus3.currentPC <= '0;
    else     bus3.currentPC <= bus3.nextPC;
  end

  typedef struct {
    bit         sel3;
    string      name;
    logic [7:0] npc;
    logic       fv;
    logic       fl;
    logic       hd;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t       m_e;
  logic [7:0] a_npc;
  logic       a_fv, a_fl, a_hd;

  // Monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() != 0) begin
      m_e = q.pop_front();
      if (m_e.sel3) begin
        a_npc = bus3.nextPC; a_fv = bus3.fetch_valid; a_fl = bus3.if_flush; a_hd = bus3.halted;
      end else begin
        a_npc = bus.nextPC;  a_fv = bus.fetch_valid;  a_fl = bus.if_flush;  a_hd = bus.halted;
      end
      n_checks++;
      if ({a_npc, a_fv, a_fl, a_hd} !== {m_e.npc, m_e.fv, m_e.fl, m_e.hd}) begin
        n_fail++;
        $display("FAIL %s: got nextPC=%h fetch_valid=%b if_flush=%b halted=%b, expected nextPC=%h fetch_valid=%b if_flush=%b halted=%b",
                 m_e.name, a_npc, a_fv, a_fl, a_hd, m_e.npc, m_e.fv, m_e.fl, m_e.hd);
      end
    end
  end

  task automatic cyc(input string name, input logic [7:0] npc, input logic fv,
                     input logic fl, input logic hd, input bit sel3 = 1'b0);
    exp_t e;
    e.sel3 = sel3; e.name = name; e.npc = npc; e.fv = fv; e.fl = fl; e.hd = hd;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Stall one cycle while loading the PC model with a new address
  task automatic force_pc(input string name, input logic [7:0] cur, input logic [7:0] v);
    bus.stall = 1'b1; force_en = 1'b1; force_val = v;
    cyc(name, cur, 1'b0, 1'b0, 1'b0);
    bus.stall = 1'b0; force_en = 1'b0;
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.imem_ready = 1'b1;  bus.stall = 1'b0;  bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus.jump = 1'b0;        bus.jump_target = '0; bus.halt = 1'b0;      bus.resume = 1'b0;
    bus3.imem_ready = 1'b1; bus3.stall = 1'b0; bus3.branch_taken = 1'b0; bus3.branch_target = '0;
    bus3.jump = 1'b0;       bus3.jump_target = '0; bus3.halt = 1'b0;    bus3.resume = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    cyc("reset_state", 8'h01, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // Sequential fetch and wrap
    cyc("inc_pc0", 8'h01, 1'b1, 1'b0, 1'b0);
    cyc("inc_pc1", 8'h02, 1'b1, 1'b0, 1'b0);
    cyc("inc_pc2", 8'h03, 1'b1, 1'b0, 1'b0);
    cyc("inc_pc3", 8'h04, 1'b1, 1'b0, 1'b0);
    force_pc("force_ff", 8'h04, 8'hFF);
    cyc("wrap_ff", 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("after_wrap", 8'h01, 1'b1, 1'b0, 1'b0);

    // Jump beats branch in the same cycle, one bubble
    force_pc("force_10", 8'h01, 8'h10);
    bus.branch_taken = 1'b1; bus.branch_target = 8'h40; bus.jump = 1'b1; bus.jump_target = 8'h80;
    cyc("redirect_prio", 8'h80, 1'b0, 1'b1, 1'b0);
    bus.branch_taken = 1'b0; bus.jump = 1'b0;
    cyc("bubble_1", 8'h80, 1'b0, 1'b0, 1'b0);
    cyc("fetch_80", 8'h81, 1'b1, 1'b0, 1'b0);

    // Memory not ready for three cycles
    force_pc("force_05", 8'h81, 8'h05);
`ifdef PC_CTRL_PERF_EN
    sc_snap = stall_cnt;
`endif
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("mem_wait", 8'h05, 1'b0, 1'b0, 1'b0);
    bus.imem_ready = 1'b1;
    cyc("mem_ready", 8'h06, 1'b1, 1'b0, 1'b0);
`ifdef PC_CTRL_PERF_EN
    check16("stall_cnt_mem_wait", stall_cnt - sc_snap, 16'd3);
`endif
    cyc("after_ready", 8'h07, 1'b1, 1'b0, 1'b0);

    // Halt for ten cycles, then resume
    force_pc("force_20", 8'h07, 8'h20);
    bus.halt = 1'b1;
    cyc("halt_accept", 8'h20, 1'b0, 1'b0, 1'b0);
    bus.halt = 1'b0;
    for (int i = 0; i < 10; i++) cyc("halted_hold", 8'h20, 1'b0, 1'b0, 1'b1);
    bus.resume = 1'b1;
    cyc("resume_cycle", 8'h20, 1'b0, 1'b0, 1'b1);
    bus.resume = 1'b0;
    cyc("post_resume", 8'h21, 1'b1, 1'b0, 1'b0);

    // halt+resume stays halted; redirect leaves HALTED
    bus.halt = 1'b1;
    cyc("halt2_accept", 8'h21, 1'b0, 1'b0, 1'b0);
    bus.resume = 1'b1;
    cyc("halt_and_resume", 8'h21, 1'b0, 1'b0, 1'b1);
    bus.halt = 1'b0; bus.resume = 1'b0;
    cyc("still_halted", 8'h21, 1'b0, 1'b0, 1'b1);
    bus.jump = 1'b1; bus.jump_target = 8'h30;
    cyc("redirect_from_halt", 8'h30, 1'b0, 1'b1, 1'b1);
    bus.jump = 1'b0;
    cyc("bubble_after_halt", 8'h30, 1'b0, 1'b0, 1'b0);
    cyc("fetch_30", 8'h31, 1'b1, 1'b0, 1'b0);

    // Redirect from WAIT_MEM
    bus.imem_ready = 1'b0;
    cyc("wait_a", 8'h31, 1'b0, 1'b0, 1'b0);
    bus.branch_taken = 1'b1; bus.branch_target = 8'h50;
    cyc("redirect_from_wait", 8'h50, 1'b0, 1'b1, 1'b0);
    bus.branch_taken = 1'b0; bus.imem_ready = 1'b1;
    cyc("bubble_b", 8'h50, 1'b0, 1'b0, 1'b0);
    cyc("fetch_50", 8'h51, 1'b1, 1'b0, 1'b0);

    // Stall holds WAIT_MEM even when memory becomes ready
    bus.imem_ready = 1'b0;
    cyc("wait_b", 8'h51, 1'b0, 1'b0, 1'b0);
    bus.imem_ready = 1'b1; bus.stall = 1'b1;
    cyc("wait_stall", 8'h51, 1'b0, 1'b0, 1'b0);
    bus.stall = 1'b0;
    cyc("wait_exit", 8'h52, 1'b1, 1'b0, 1'b0);

    // Three bubbles; stall in the middle does not extend them
    bus3.jump = 1'b1; bus3.jump_target = 8'h07;
    cyc("d3_jump", 8'h07, 1'b0, 1'b1, 1'b0, 1'b1);
    bus3.jump = 1'b0;
    cyc("d3_bubble1", 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
    bus3.stall = 1'b1;
    cyc("d3_bubble2_stall", 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
    bus3.stall = 1'b0;
    cyc("d3_bubble3", 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("d3_fetch_07", 8'h08, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef PC_CTRL_PERF_EN
    check16("d3_redirect_cnt", redirect_cnt3, 16'd1);
`endif

    // Async reset during the second bubble
    bus3.jump = 1'b1;
    cyc("d3_jump_b", 8'h07, 1'b0, 1'b1, 1'b0, 1'b1);
    bus3.jump = 1'b0;
    cyc("d3_bubble1_b", 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
`ifdef PC_CTRL_PERF_EN
    check16("d3_redirect_cnt_rst", redirect_cnt3, 16'd0);
`endif
    cyc("d3_async_rst", 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    cyc("d3_after_rst", 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("d3_after_rst2", 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected records left, required 0", q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
